// File: rtl/sync_fifo_pkt.sv
// sync_fifo_pkt: single-clock AXI-Stream FIFO with tlast framing, an optional
// store-and-forward packet mode and almost-full/almost-empty flags.
// Storage is a register array of {tlast, tdata}, and the output is
// first-word-fall-through.
// Optional feature macro: SYNC_FIFO_PKT_DROP_EN adds i_tdrop. A write beat
// with i_tdrop set discards the packet that is still being written.
module sync_fifo_pkt #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter bit PKT_MODE  = 1'b1,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
`ifdef SYNC_FIFO_PKT_DROP_EN
    input  logic             i_tdrop,
`endif
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [15:0]      space,
    output logic [15:0]      occupied,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [15:0]      pkt_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Pointers carry one extra bit so that full and empty can be told apart.
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [PW-1:0]  cm_ptr_r;
    logic           cut_thru_r;
    logic [15:0]    pkt_count_r;
    logic [WIDTH:0] mem_r [DEPTH];

    logic [PW-1:0]  occ_s;
    logic           full_s;
    logic [WIDTH:0] head_s;
    logic           wr_fire_s;
    logic           rd_fire_s;
    logic           drop_s;
    logic           store_s;
    logic           force_s;
    logic [PW-1:0]  cm_next_s;
    logic           ct_next_s;

    // Fill level, flags and the fall-through head of the FIFO.
    always_comb begin
        occ_s        = wr_ptr_r - rd_ptr_r;
        full_s       = (occ_s == PW'(DEPTH));
        occupied     = 16'(occ_s);
        space        = 16'(DEPTH) - 16'(occ_s);
        i_tready     = ~full_s & ~reset;
        almost_full  = (16'(occ_s) >= 16'(AFULL_TH));
        almost_empty = (16'(occ_s) <= 16'(AEMPTY_TH));
        if (PKT_MODE) begin
            o_tvalid = (cm_ptr_r != rd_ptr_r);
        end else begin
            o_tvalid = (wr_ptr_r != rd_ptr_r);
        end
        head_s    = mem_r[rd_ptr_r[AW-1:0]];
        o_tdata   = head_s[WIDTH-1:0];
        // Stored tlast is stale when the head is empty, so mask it.
        o_tlast   = head_s[WIDTH] & o_tvalid;
        pkt_count = pkt_count_r;
    end

    // Transfer qualifiers. A clear cycle swallows any handshake.
    always_comb begin
        wr_fire_s = i_tvalid & i_tready & ~clear;
        rd_fire_s = o_tvalid & o_tready & ~clear;
`ifdef SYNC_FIFO_PKT_DROP_EN
        drop_s    = wr_fire_s & i_tdrop;
`else
        drop_s    = 1'b0;
`endif
        store_s   = wr_fire_s & ~drop_s;
        // The FIFO holds a single unfinished packet and cannot accept its tail.
        force_s   = PKT_MODE & full_s & (cm_ptr_r == rd_ptr_r);
    end

    // Next commit pointer and cut-through flag.
    always_comb begin
        cm_next_s = cm_ptr_r;
        ct_next_s = cut_thru_r;
        if (!PKT_MODE) begin
            if (store_s) begin
                cm_next_s = wr_ptr_r + PW'(1);
            end else begin
                cm_next_s = cm_ptr_r;
            end
        end else if (force_s) begin
            // Publish the oversize packet and let its remainder flow through.
            cm_next_s = wr_ptr_r;
            ct_next_s = 1'b1;
        end else if (store_s && (i_tlast || cut_thru_r)) begin
            cm_next_s = wr_ptr_r + PW'(1);
            ct_next_s = cut_thru_r & ~i_tlast;
        end else if (drop_s) begin
            ct_next_s = 1'b0;
        end else begin
            cm_next_s = cm_ptr_r;
            ct_next_s = cut_thru_r;
        end
    end

    // Pointer, commit and packet-count state. Reset has priority over clear.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            cm_ptr_r    <= '0;
            cut_thru_r  <= 1'b0;
            pkt_count_r <= 16'h0000;
        end else begin
            if (rd_fire_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            if (drop_s) begin
                wr_ptr_r <= cm_ptr_r;
            end else if (store_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            cm_ptr_r   <= cm_next_s;
            cut_thru_r <= ct_next_s;
            if ((store_s & i_tlast) && !(rd_fire_s & head_s[WIDTH])) begin
                if (pkt_count_r != 16'hFFFF) begin
                    pkt_count_r <= pkt_count_r + 16'h0001;
                end
            end else if (!(store_s & i_tlast) && (rd_fire_s & head_s[WIDTH])) begin
                if (pkt_count_r != 16'h0000) begin
                    pkt_count_r <= pkt_count_r - 16'h0001;
                end
            end
        end
    end

    // Storage write. The array is intentionally left untouched by reset and clear.
    always_ff @(posedge clock) begin
        if (store_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {i_tlast, i_tdata};
        end
    end

endmodule
